// File: rtl/axi_cfg_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd_valid/cmd_ready request into
// one AW+W+B write or AR+R read, then reports it with a one-cycle rsp_valid.
`timescale 1ns/1ps
module axi_cfg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              Local_Reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              err_sticky,
  input  logic                              err_clear,
  output logic [15:0]                       wr_count,
  output logic [15:0]                       rd_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_REQ  | AW and W offered independently until both have handshaken
  // WR_RESP | BREADY high, waiting for the write response
  // RD_REQ  | ARVALID high, waiting for ARREADY
  // RD_DATA | RREADY high, waiting for read data
  // RSP     | rsp_valid pulse, counters and error flag already updated

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            err_q, err_d, err_set;
  logic [15:0]     wr_count_q, wr_count_d, rd_count_q, rd_count_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; whichever finishes first just waits
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          wr_count_d  = wr_count_q + 16'd1;
          err_set     = (M_AXI_BRESP != 2'b00);
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rd_count_d  = rd_count_q + 16'd1;
          err_set     = (M_AXI_RRESP != 2'b00);
        end
      end
      RSP: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
    err_d = err_set | (err_q & ~err_clear);
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_q       <= 1'b0;
      wr_count_q  <= 16'd0;
      rd_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign err_sticky    = err_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_cfg_master.sv
// Directed bench for axi_cfg_master: configurable AXI-Lite slave, scoreboard of
// expected responses, and per-cycle protocol checks.
`timescale 1ns/1ps
module tb_axi_cfg_master;
  localparam int DW = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          err_sticky, err_clear;
  logic [15:0]   wr_count, rd_count;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_cfg_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .Local_Reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .err_sticky(err_sticky), .err_clear(err_clear),
    .wr_count(wr_count), .rd_count(rd_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave configuration, set by the directed steps
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_mode = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic        b_hold = 1'b0;

  int   aw_cnt, w_cnt, ar_cnt;
  logic aw_got, w_got, b_pend, r_pend;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign bvalid  = b_pend && !b_hold;
  assign bresp   = bresp_cfg;
  // r_mode 1: RVALID rises with ARREADY; r_mode 2: RVALID (with junk data) before ARREADY
  assign rvalid  = r_pend || (arvalid && ((r_mode == 1 && arready) || r_mode == 2));
  assign rdata   = (r_mode == 2 && !r_pend) ? 32'hBAD0_BAD0 : rdata_cfg;
  assign rresp   = rresp_cfg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) b_pend <= 1'b0;
      if (arvalid && arready) r_pend <= 1'b1;
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  int            aw_hi = 0, w_hi = 0, b_hs = 0, rsp_cnt = 0;
  logic [AW-1:0] last_awaddr = '0, prev_awaddr = '0, prev_araddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [3:0]    last_wstrb = '0;
  logic          prev_aw_pend = 1'b0, prev_ar_pend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_aw_pend = 1'b0;
      prev_ar_pend = 1'b0;
    end else begin
      chk("aw_ar_exclusive", awvalid & arvalid, 0);
      chk("rready_before_ar", rready & ~r_pend, 0);
      if (prev_aw_pend) chk("aw_held_stable", {awvalid, awaddr}, {1'b1, prev_awaddr});
      if (prev_ar_pend) chk("ar_held_stable", {arvalid, araddr}, {1'b1, prev_araddr});
      prev_aw_pend = awvalid && !awready;
      prev_ar_pend = arvalid && !arready;
      prev_awaddr  = awaddr;
      prev_araddr  = araddr;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid && awready) last_awaddr = awaddr;
      if (wvalid && wready) begin
        last_wdata = wdata;
        last_wstrb = wstrb;
      end
      if (bvalid && bready) b_hs++;
      if (rsp_valid) begin
        exp_t e;
        rsp_cnt++;
        n_assert++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL rsp_unexpected: observed rsp_valid with %0d queued, expected a queued entry", sb.size());
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", rsp_resp, e.resp);
        end
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_resp, input logic clr, output int lat);
    int k;
    int t0;
    exp_t e;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    aw_hi = 0; w_hi = 0; b_hs = 0; rsp_cnt = 0;
    e.rdata = exp_rdata;
    e.resp  = exp_resp;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb; err_clear = clr;
    t0 = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_addr = '1; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    lat = cyc - t0;
    err_clear = 1'b0;
    @(negedge clk);
    chk("rsp_valid_one_cycle", rsp_valid, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("err_cleared", err_sticky, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    err_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_resp, err_sticky}, 0);
    chk("rst_counts", {wr_count, rd_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // single write, slave always ready
    do_cmd(1'b1, 9'h000, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00, 1'b0, lat);
    chk("w1_latency", lat, 3);
    chk("w1_aw_cycles", aw_hi, 1);
    chk("w1_w_cycles", w_hi, 1);
    chk("w1_b_hs", b_hs, 1);
    chk("w1_wdata", last_wdata, 32'hA5A5_0001);
    chk("w1_wr_count", wr_count, 1);

    // AWREADY held off 3 cycles
    aw_delay = 3;
    do_cmd(1'b1, 9'h1FC, 32'h1234_5678, 4'b0101, 32'h0, 2'b00, 1'b0, lat);
    aw_delay = 0;
    chk("w2_latency", lat, 6);
    chk("w2_aw_cycles", aw_hi, 4);
    chk("w2_w_cycles", w_hi, 1);
    chk("w2_b_hs", b_hs, 1);
    chk("w2_rsp_count", rsp_cnt, 1);
    chk("w2_awaddr", last_awaddr, 9'h1FC);
    chk("w2_wdata", last_wdata, 32'h1234_5678);
    chk("w2_wstrb", last_wstrb, 4'b0101);
    chk("w2_wr_count", wr_count, 2);

    // WREADY held off 2 cycles
    w_delay = 2;
    do_cmd(1'b1, 9'h010, 32'hFFFF_0000, 4'b1100, 32'h0, 2'b00, 1'b0, lat);
    w_delay = 0;
    chk("w3_latency", lat, 5);
    chk("w3_aw_cycles", aw_hi, 1);
    chk("w3_w_cycles", w_hi, 3);
    chk("w3_wr_count", wr_count, 3);

    // read, RVALID together with ARREADY
    r_mode = 1; rdata_cfg = 32'hA5A5_0001;
    do_cmd(1'b0, 9'h000, 32'h0, 4'h0, 32'hA5A5_0001, 2'b00, 1'b0, lat);
    chk("r1_latency", lat, 3);
    chk("r1_rd_count", rd_count, 1);
    chk("r1_err", err_sticky, 0);

    // read, RVALID with junk data before a late ARREADY
    r_mode = 2; ar_delay = 2; rdata_cfg = 32'h0BAD_F00D;
    do_cmd(1'b0, 9'h044, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1'b0, lat);
    r_mode = 0; ar_delay = 0;
    chk("r2_latency", lat, 5);
    chk("r2_rd_count", rd_count, 2);

    // read error, then clear
    rresp_cfg = 2'b10; rdata_cfg = 32'h0000_00FF;
    do_cmd(1'b0, 9'h008, 32'h0, 4'h0, 32'h0000_00FF, 2'b10, 1'b0, lat);
    chk("r3_err_set", err_sticky, 1);
    chk("r3_rd_count", rd_count, 3);
    pulse_clear();

    // write error
    rresp_cfg = 2'b00; bresp_cfg = 2'b10;
    do_cmd(1'b1, 9'h020, 32'h0000_0042, 4'h1, 32'h0, 2'b10, 1'b0, lat);
    bresp_cfg = 2'b00;
    chk("w4_err_set", err_sticky, 1);
    chk("w4_wr_count", wr_count, 4);
    pulse_clear();

    // error arriving while err_clear is held: set wins
    rresp_cfg = 2'b11; rdata_cfg = 32'hCAFE_0011;
    do_cmd(1'b0, 9'h0C0, 32'h0, 4'h0, 32'hCAFE_0011, 2'b11, 1'b1, lat);
    rresp_cfg = 2'b00;
    chk("r4_set_beats_clear", err_sticky, 1);
    chk("r4_rd_count", rd_count, 4);

    // reset while waiting in WR_RESP
    b_hold = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h0AC; cmd_wdata = 32'h7777_7777; cmd_wstrb = 4'hF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!bready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_bready", bready, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_axi", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_mid_addr", {awaddr, wdata, wstrb}, 0);
    chk("rst_mid_rsp", {rsp_valid, rsp_resp, err_sticky}, 0);
    chk("rst_mid_rdata", rsp_rdata, 0);
    chk("rst_mid_counts", {wr_count, rd_count}, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    b_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_no_rsp", sb.size(), 0);

    rdata_cfg = 32'h5A5A_0002;
    do_cmd(1'b0, 9'h004, 32'h0, 4'h0, 32'h5A5A_0002, 2'b00, 1'b0, lat);
    chk("r5_latency", lat, 3);
    chk("r5_rd_count", rd_count, 1);

    // rd_count wrap, counter preloaded through the flop
    @(negedge clk);
    force dut.rd_count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.rd_count_q;
    @(negedge clk);
    chk("wrap_preload", rd_count, 16'hFFFE);
    rdata_cfg = 32'h0000_0001;
    do_cmd(1'b0, 9'h100, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 1'b0, lat);
    chk("wrap_ffff", rd_count, 16'hFFFF);
    rdata_cfg = 32'h0000_0002;
    do_cmd(1'b0, 9'h104, 32'h0, 4'h0, 32'h0000_0002, 2'b00, 1'b0, lat);
    chk("wrap_zero", rd_count, 16'h0000);
    chk("wrap_wr_count", wr_count, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
